// File: rtl/alu_cmd_sequencer_if.sv
// Command / response handshake bundle for alu_cmd_sequencer.
//   master : command source / response sink (host, CPU, testbench)
//   slave  : the sequencer
// Signals:
//   cmd_valid/cmd_ready   command handshake
//   cmd_op/cmd_a/cmd_b    opcode and operands
//   cmd_use_acc           take operand A from the accumulator (ALU_SEQ_ACCUM_EN only)
//   rsp_valid/rsp_ready   response handshake
//   rsp_result/rsp_carry  captured ALU outputs
//   rsp_err               illegal opcode indication
interface alu_cmd_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
`ifdef ALU_SEQ_ACCUM_EN
    logic             cmd_use_acc;
`endif
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carry;
    logic             rsp_err;

`ifdef ALU_SEQ_ACCUM_EN
    modport master (output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
                    input  cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_err);
    modport slave  (input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
                    output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_err);
`else
    modport master (output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
                    input  cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_err);
    modport slave  (input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
                    output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_err);
`endif
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command-side driver for the combinational 8-bit ALU.
// Takes one {opcode, A, B} command at a time, registers it onto the ALU
// inputs, waits ALU_LAT cycles, captures result/carry and returns them
// over the response handshake. Illegal opcodes (110/111) skip the wait and
// respond with rsp_err=1 and zero data.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   bus (slave)         command/response handshake (alu_cmd_sequencer_if)
//   alu_a/alu_b         registered ALU operands (hold between commands)
//   alu_opcode          registered ALU opcode
//   alu_result/carry    ALU outputs, sampled at the end of the wait
//   busy                high outside IDLE
//   op_count            completed responses since reset, wraps
//
// Optional build macro ALU_SEQ_ACCUM_EN: adds bus.cmd_use_acc and an
// accumulator that tracks the last good result; when cmd_use_acc=1 the
// accumulator replaces cmd_a as ALU operand A.
//
// state | meaning
// IDLE  | cmd_ready=1, waiting for a command
// WAIT  | ALU inputs driven, counting down the settle time
// RESP  | rsp_valid=1, holding the response until rsp_ready
module alu_cmd_sequencer #(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    alu_cmd_sequencer_if.slave  bus,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    output logic [2:0]          alu_opcode,
    input  logic [WIDTH-1:0]    alu_result,
    input  logic                alu_carry,
    output logic                busy,
    output logic [CNT_W-1:0]    op_count
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(ALU_LAT - 1);

    state_t     state_q, state_d;
    logic [3:0] wait_cnt;
    logic       op_legal;
    logic       cmd_fire;
    logic       wait_done;
    logic       rsp_fire;

`ifdef ALU_SEQ_ACCUM_EN
    logic [WIDTH-1:0] acc_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cmd_fire  = 1'b0;
        wait_done = 1'b0;
        rsp_fire  = 1'b0;
        op_legal  = (bus.cmd_op <= 3'd5);
        case (state_q)
            IDLE: if (bus.cmd_valid) begin
                cmd_fire = 1'b1;
                state_d  = op_legal ? WAIT : RESP;
            end
            WAIT: if (wait_cnt == 4'd0) begin
                wait_done = 1'b1;
                state_d   = RESP;
            end
            RESP: if (bus.rsp_ready) begin
                rsp_fire = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are decoded from state only, never from cmd_valid.
    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign busy          = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a          <= '0;
            alu_b          <= '0;
            alu_opcode     <= '0;
            wait_cnt       <= '0;
            bus.rsp_result <= '0;
            bus.rsp_carry  <= 1'b0;
            bus.rsp_err    <= 1'b0;
            op_count       <= '0;
`ifdef ALU_SEQ_ACCUM_EN
            acc_q          <= '0;
`endif
        end else begin
            if (cmd_fire) begin
                // ALU registers load even for illegal opcodes.
`ifdef ALU_SEQ_ACCUM_EN
                alu_a <= bus.cmd_use_acc ? acc_q : bus.cmd_a;
`else
                alu_a <= bus.cmd_a;
`endif
                alu_b      <= bus.cmd_b;
                alu_opcode <= bus.cmd_op;
                wait_cnt   <= WAIT_INIT;
                if (!op_legal) begin
                    bus.rsp_result <= '0;
                    bus.rsp_carry  <= 1'b0;
                    bus.rsp_err    <= 1'b1;
                end
            end
            if (state_q == WAIT && wait_cnt != 4'd0)
                wait_cnt <= wait_cnt - 4'd1;
            if (wait_done) begin
                bus.rsp_result <= alu_result;
                bus.rsp_carry  <= alu_carry;
                bus.rsp_err    <= 1'b0;
            end
            if (rsp_fire) begin
                op_count <= op_count + 1'b1;
`ifdef ALU_SEQ_ACCUM_EN
                if (!bus.rsp_err) acc_q <= bus.rsp_result;
`endif
            end
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: one instance with ALU_LAT=1/CNT_W=8 and one
// with ALU_LAT=3/CNT_W=3, each fed by a behavioural ALU.
module tb_alu_cmd_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       err;
        logic       carry;
        logic [7:0] res;
    } rsp_t;

    logic rst, rst3;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   ops_done = 0;
    rsp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    alu_cmd_sequencer_if #(.WIDTH(8)) c1 ();
    alu_cmd_sequencer_if #(.WIDTH(8)) c3 ();

    logic [7:0] alu_a1, alu_b1, alu_res1, opc1;
    logic [2:0] alu_op1;
    logic       alu_c1, busy1;
    logic [7:0] alu_a3, alu_b3, alu_res3;
    logic [2:0] alu_op3, opc3;
    logic       alu_c3, busy3;

    alu_cmd_sequencer #(.WIDTH(8), .ALU_LAT(1), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .bus(c1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_opcode(alu_op1),
        .alu_result(alu_res1), .alu_carry(alu_c1),
        .busy(busy1), .op_count(opc1));

    alu_cmd_sequencer #(.WIDTH(8), .ALU_LAT(3), .CNT_W(3)) u_dut3 (
        .clk(clk), .rst(rst3), .bus(c3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_opcode(alu_op3),
        .alu_result(alu_res3), .alu_carry(alu_c3),
        .busy(busy3), .op_count(opc3));

    // Behavioural alu_8bit: carry is carry-out for ADD, borrow for SUB.
    function automatic logic [8:0] alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, ~a};
            default: return 9'd0;
        endcase
    endfunction

    always_comb {alu_c1, alu_res1} = alu_model(alu_op1, alu_a1, alu_b1);
    always_comb {alu_c3, alu_res3} = alu_model(alu_op3, alu_a3, alu_b3);

    function automatic rsp_t expect_rsp(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        if (op > 3'd5) return {1'b1, 1'b0, 8'h00};
        r = alu_model(op, a, b);
        return {1'b0, r[8], r[7:0]};
    endfunction

    task automatic send1(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic ua, output int acc_cyc, output bit ok);
        c1.cmd_op = op; c1.cmd_a = a; c1.cmd_b = b;
`ifdef ALU_SEQ_ACCUM_EN
        c1.cmd_use_acc = ua;
`else
        if (ua) c1.cmd_a = a;
`endif
        c1.cmd_valid = 1'b1;
        ok = 1'b0;
        acc_cyc = 0;
        for (int i = 0; i < 20; i++) begin
            if (c1.cmd_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
            acc_cyc = cyc;
        end
        c1.cmd_valid = 1'b0;
    endtask

    task automatic collect1(output rsp_t got, output int lat, output bit ok);
        lat = 1;
        while (!c1.rsp_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        ok  = c1.rsp_valid;
        got = {c1.rsp_err, c1.rsp_carry, c1.rsp_result};
        if (ok) begin
            c1.rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            c1.rsp_ready = 1'b0;
            ops_done++;
        end
    endtask

    task automatic send3(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, output bit ok);
        c3.cmd_op = op; c3.cmd_a = a; c3.cmd_b = b; c3.cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (c3.cmd_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
        end
        c3.cmd_valid = 1'b0;
    endtask

    task automatic collect3(output rsp_t got, output int lat, output bit ok);
        lat = 1;
        while (!c3.rsp_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        ok  = c3.rsp_valid;
        got = {c3.rsp_err, c3.rsp_carry, c3.rsp_result};
        if (ok) begin
            c3.rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            c3.rsp_ready = 1'b0;
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        c1.cmd_valid = 1'b0;
        c1.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ops_done = 0;
        sb.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1; rst3 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({c1.cmd_ready, c1.rsp_valid, busy1} !== 3'b100) begin
            n_fail++; $display("FAIL reset_handshake: got %b required 100", {c1.cmd_ready, c1.rsp_valid, busy1});
        end
        n_tests++;
        if ({opc1, alu_a1, alu_b1, alu_op1} !== 27'd0) begin
            n_fail++; $display("FAIL reset_regs: cnt=%h a=%h b=%h op=%h required 0", opc1, alu_a1, alu_b1, alu_op1);
        end
        n_tests++;
        if ({c1.rsp_err, c1.rsp_carry, c1.rsp_result} !== 10'd0) begin
            n_fail++; $display("FAIL reset_rsp: got %h required 0", {c1.rsp_err, c1.rsp_carry, c1.rsp_result});
        end
        n_tests++;
        if ({c3.cmd_ready, c3.rsp_valid, busy3, opc3} !== 6'b100000) begin
            n_fail++; $display("FAIL reset_dut3: got %b required 100000", {c3.cmd_ready, c3.rsp_valid, busy3, opc3});
        end
        rst = 1'b0; rst3 = 1'b0;
    endtask

    task automatic test_add;
        rsp_t got, exp; int lat, ac; bit ok1, ok2;
        send1(3'd0, 8'hD7, 8'h41, 1'b0, ac, ok1);
        sb.push_back({1'b0, 1'b1, 8'h18});
        collect1(got, lat, ok2);
        exp = sb.pop_front();
        n_tests++;
        if (!(ok1 && ok2) || got !== exp) begin
            n_fail++; $display("FAIL add_result: got %h required %h (handshake %0d%0d)", got, exp, ok1, ok2);
        end
        n_tests++;
        if (lat !== 2) begin n_fail++; $display("FAIL add_latency: got %0d required 2", lat); end
        n_tests++;
        if ({c1.cmd_ready, c1.rsp_valid, busy1} !== 3'b100) begin
            n_fail++; $display("FAIL add_post_idle: got %b required 100", {c1.cmd_ready, c1.rsp_valid, busy1});
        end
        n_tests++;
        if ({alu_a1, alu_b1, alu_op1} !== {8'hD7, 8'h41, 3'd0}) begin
            n_fail++; $display("FAIL add_alu_hold: got %h/%h/%h required d7/41/0", alu_a1, alu_b1, alu_op1);
        end
        n_tests++;
        if (opc1 !== 8'(ops_done)) begin n_fail++; $display("FAIL add_count: got %0d required %0d", opc1, ops_done); end
    endtask

    task automatic test_ops;
        logic [2:0] ops [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        logic [7:0] as  [5] = '{8'h37, 8'h6D, 8'h6D, 8'h6D, 8'h6D};
        logic [7:0] bs  [5] = '{8'h01, 8'h51, 8'h51, 8'h51, 8'h51};
        logic [7:0] rs  [5] = '{8'h36, 8'h41, 8'h7D, 8'h3C, 8'h92};
        rsp_t got, exp; int lat, ac; bit ok1, ok2;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send1(ops[i], as[i], bs[i], 1'b0, ac, ok1);
            sb.push_back({1'b0, 1'b0, rs[i]});
            collect1(got, lat, ok2);
            exp = sb.pop_front();
            n_tests++;
            if (!(ok1 && ok2) || got !== exp || lat !== 2) begin
                n_fail++; $display("FAIL ops_%0d: got %h lat %0d required %h lat 2", ops[i], got, lat, exp);
            end
        end
        n_tests++;
        if (opc1 !== 8'd5) begin n_fail++; $display("FAIL ops_count: got %0d required 5", opc1); end
    endtask

    task automatic test_illegal;
        rsp_t got, exp; int lat, ac; bit ok1, ok2;
        for (int k = 6; k < 8; k++) begin
            send1(3'(k), 8'hFF, 8'h5A, 1'b0, ac, ok1);
            sb.push_back({1'b1, 1'b0, 8'h00});
            collect1(got, lat, ok2);
            exp = sb.pop_front();
            n_tests++;
            if (!(ok1 && ok2) || got !== exp || lat !== 1) begin
                n_fail++; $display("FAIL illegal_%0d: got %h lat %0d required %h lat 1", k, got, lat, exp);
            end
            n_tests++;
            if ({alu_a1, alu_b1, alu_op1} !== {8'hFF, 8'h5A, 3'(k)} || opc1 !== 8'(ops_done)) begin
                n_fail++; $display("FAIL illegal_regs_%0d: a=%h b=%h op=%h cnt=%0d required ff/5a/%0d cnt %0d",
                                   k, alu_a1, alu_b1, alu_op1, opc1, k, ops_done);
            end
        end
    endtask

    task automatic test_backpressure;
        rsp_t got, exp; int lat, ac; bit ok1, ok2;
        send1(3'd2, 8'h0F, 8'h3C, 1'b0, ac, ok1);
        sb.push_back({1'b0, 1'b0, 8'h0C});
        for (int i = 0; i < 10 && !c1.rsp_valid; i++) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (!ok1 || {c1.rsp_valid, c1.cmd_ready} !== 2'b10 ||
                {c1.rsp_err, c1.rsp_carry, c1.rsp_result} !== sb[0]) begin
                n_fail++; $display("FAIL backpressure_hold_%0d: valid=%b ready=%b rsp=%h required 1/0/%h",
                                   i, c1.rsp_valid, c1.cmd_ready, {c1.rsp_err, c1.rsp_carry, c1.rsp_result}, sb[0]);
            end
            if (i == 1) begin
                c1.cmd_op = 3'd0; c1.cmd_a = 8'h01; c1.cmd_b = 8'h01; c1.cmd_valid = 1'b1;
            end else begin
                c1.cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        c1.cmd_valid = 1'b0;
        collect1(got, lat, ok2);
        exp = sb.pop_front();
        n_tests++;
        if (!ok2 || got !== exp) begin n_fail++; $display("FAIL backpressure_result: got %h required %h", got, exp); end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if ({c1.rsp_valid, busy1} !== 2'b00) begin
                n_fail++; $display("FAIL backpressure_no_accept_%0d: valid=%b busy=%b required 0/0", i, c1.rsp_valid, busy1);
            end
            @(negedge clk);
        end
        n_tests++;
        if (opc1 !== 8'(ops_done)) begin n_fail++; $display("FAIL backpressure_count: got %0d required %0d", opc1, ops_done); end
    endtask

    task automatic test_back_to_back;
        rsp_t got, exp; int lat, ac, prev; bit ok1, ok2;
        logic [2:0] op; logic [7:0] a, b;
        prev = 0;
        for (int k = 0; k < 8; k++) begin
            op = 3'($urandom_range(0, 5));
            a  = 8'($urandom);
            b  = 8'($urandom);
            send1(op, a, b, 1'b0, ac, ok1);
            sb.push_back(expect_rsp(op, a, b));
            collect1(got, lat, ok2);
            exp = sb.pop_front();
            n_tests++;
            if (!(ok1 && ok2) || got !== exp) begin
                n_fail++; $display("FAIL b2b_%0d op%0d %h,%h: got %h required %h", k, op, a, b, got, exp);
            end
            if (k > 0) begin
                n_tests++;
                if (ac - prev !== 3) begin n_fail++; $display("FAIL b2b_spacing_%0d: got %0d required 3", k, ac - prev); end
            end
            prev = ac;
        end
    endtask

`ifdef ALU_SEQ_ACCUM_EN
    task automatic test_accum;
        logic [7:0] bs [3] = '{8'h05, 8'h01, 8'hEA};
        logic       us [3] = '{1'b0, 1'b1, 1'b1};
        rsp_t       es [3] = '{{1'b0, 1'b0, 8'h15}, {1'b0, 1'b0, 8'h16}, {1'b0, 1'b1, 8'h00}};
        rsp_t got, exp; int lat, ac; bit ok1, ok2;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send1(3'd0, (i == 0) ? 8'h10 : 8'h77, bs[i], us[i], ac, ok1);
            sb.push_back(es[i]);
            collect1(got, lat, ok2);
            exp = sb.pop_front();
            n_tests++;
            if (!(ok1 && ok2) || got !== exp) begin n_fail++; $display("FAIL accum_%0d: got %h required %h", i, got, exp); end
        end
        n_tests++;
        if (alu_a1 !== 8'h16) begin n_fail++; $display("FAIL accum_alu_a: got %h required 16", alu_a1); end
        c1.cmd_use_acc = 1'b0;
    endtask
`endif

    task automatic test_lat3_wrap;
        rsp_t got; int lat; bit ok1, ok2;
        for (int k = 1; k <= 8; k++) begin
            send3(3'd0, 8'(k), 8'(k), ok1);
            collect3(got, lat, ok2);
            n_tests++;
            if (!(ok1 && ok2) || got !== {1'b0, 1'b0, 8'(2 * k)} || lat !== 4) begin
                n_fail++; $display("FAIL lat3_op_%0d: got %h lat %0d required %h lat 4", k, got, lat, {1'b0, 1'b0, 8'(2 * k)});
            end
            if (k == 7) begin
                n_tests++;
                if (opc3 !== 3'd7) begin n_fail++; $display("FAIL lat3_count7: got %0d required 7", opc3); end
            end
        end
        n_tests++;
        if (opc3 !== 3'd0) begin n_fail++; $display("FAIL lat3_wrap: got %0d required 0", opc3); end
    endtask

    task automatic test_reset_in_wait;
        bit ok1;
        send3(3'd0, 8'h05, 8'h05, ok1);
        n_tests++;
        if (!ok1 || {busy3, c3.rsp_valid} !== 2'b10) begin
            n_fail++; $display("FAIL rstwait_in_wait: busy=%b valid=%b required 1/0", busy3, c3.rsp_valid);
        end
        rst3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst3 = 1'b0;
        n_tests++;
        if ({busy3, c3.rsp_valid, c3.cmd_ready, opc3, alu_a3} !== {3'b001, 3'd0, 8'h00}) begin
            n_fail++; $display("FAIL rstwait_state: busy=%b valid=%b ready=%b cnt=%0d a=%h required 0/0/1/0/00",
                               busy3, c3.rsp_valid, c3.cmd_ready, opc3, alu_a3);
        end
        c3.rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (c3.rsp_valid !== 1'b0 || opc3 !== 3'd0) begin
                n_fail++; $display("FAIL rstwait_no_rsp_%0d: valid=%b cnt=%0d required 0/0", i, c3.rsp_valid, opc3);
            end
            @(negedge clk);
        end
        c3.rsp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rst3 = 1'b1;
        c1.cmd_valid = 1'b0; c1.cmd_op = '0; c1.cmd_a = '0; c1.cmd_b = '0; c1.rsp_ready = 1'b0;
        c3.cmd_valid = 1'b0; c3.cmd_op = '0; c3.cmd_a = '0; c3.cmd_b = '0; c3.rsp_ready = 1'b0;
`ifdef ALU_SEQ_ACCUM_EN
        c1.cmd_use_acc = 1'b0;
        c3.cmd_use_acc = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_add();
        test_ops();
        test_illegal();
        test_backpressure();
        test_back_to_back();
`ifdef ALU_SEQ_ACCUM_EN
        test_accum();
`endif
        test_lat3_wrap();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
